lives_manager: RTL and testbench

LIVES_MANAGER -- requirements
Module: lives_manager

---
 rtl/lives_pkg.sv | 21 ++
 rtl/lives_manager_rise_detect.sv | 21 ++
 rtl/lives_manager.sv | 161 ++++++++++++++++
 tb/tb_lives_manager.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lives_pkg.sv
// lives_pkg: state encoding and small helpers shared by the lives manager
// slice. The grace window is compiled in only when LIVES_GRACE_EN is defined
// (see lives_manager.sv); the enum always carries S_GRACE so the debug
// encoding is identical in both builds.
package lives_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_GRACE = 3'd3,
    S_OVER  = 3'd4
  } lives_state_e;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned cur,
                                          input int unsigned ceil);
    return (cur >= ceil) ? ceil : cur + 1;
  endfunction

endpackage

// File: rtl/lives_manager_rise_detect.sv
// rise_detect: one-clock strobe on a 0->1 transition of a level input,
// judged against the value sampled on the previous clock. A level held high
// produces exactly one strobe.
module rise_detect (
  input  logic clk,
  input  logic resetN,
  input  logic sig,
  output logic rise
);

  logic prev_q;

  // History register: last clock's value of the watched input.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) prev_q <= 1'b0;
    else         prev_q <= sig;
  end

  assign rise = sig & ~prev_q;

endmodule

// File: rtl/lives_manager.sv
// lives_manager: tracks the player's lives for a game round.
//   S_IDLE -> S_ARM on startN low, S_ARM -> S_RUN on startN release (lives
//   loaded), collisions remove a life, bonuses add one (saturating), the
//   round ends in S_OVER when the count reaches zero.
// Optional feature macro: LIVES_GRACE_EN. When defined, a non-fatal hit
// enters S_GRACE for GRACE_CYCLES clocks during which collisions are ignored
// and invulnerable is high. When undefined, hits stay in S_RUN and
// invulnerable is tied low.
// Handshake note: there is no valid/ready traffic here; collision and bonus
// are level inputs whose rising edges are the events, and startN is a
// level-sensitive active-low button.
// All functional outputs are registered; dbg_state mirrors the state
// register for observation.
module lives_manager
  import lives_pkg::*;
#(
  parameter int unsigned MAX_LIVES    = 5,
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned GRACE_CYCLES = 32,
  localparam int unsigned LIVES_W     = $clog2(MAX_LIVES + 1)
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startN,
  input  logic               collision,
  input  logic               bonus,
  output logic [LIVES_W-1:0] livesNum,
  output logic               lifeLost,
  output logic               invulnerable,
  output logic               gameOver,
  output lives_state_e       dbg_state
);

  // Reject parameter sets outside the legal ranges at elaboration.
  if (MAX_LIVES < 1 || MAX_LIVES > 15 || INIT_LIVES < 1 ||
      INIT_LIVES > MAX_LIVES || GRACE_CYCLES < 1) begin : g_bad_params
    $error("lives_manager: illegal MAX_LIVES/INIT_LIVES/GRACE_CYCLES");
  end

  lives_state_e        state_q, state_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic                life_lost_q, life_lost_d;
  logic                over_q;
  logic                col_rise, bon_rise;

  rise_detect u_col_rise (
    .clk    (clk),
    .resetN (resetN),
    .sig    (collision),
    .rise   (col_rise)
  );

  rise_detect u_bon_rise (
    .clk    (clk),
    .resetN (resetN),
    .sig    (bonus),
    .rise   (bon_rise)
  );

`ifdef LIVES_GRACE_EN
  localparam int unsigned TIMER_W = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(GRACE_CYCLES - 1);

  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                invul_q;
`endif

  // Next-state, next-count and pulse decode.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    life_lost_d = 1'b0;
`ifdef LIVES_GRACE_EN
    timer_d     = timer_q;
`endif
    case (state_q)
      S_IDLE: begin
        lives_d = '0;
        if (!startN) state_d = S_ARM;
      end
      S_ARM: begin
        if (startN) begin
          state_d = S_RUN;
          lives_d = LIVES_W'(INIT_LIVES);
        end
      end
      S_RUN: begin
        if (col_rise) begin
          life_lost_d = 1'b1;
          // A bonus on the same clock cancels the lost life.
          if (!bon_rise) lives_d = lives_q - 1'b1;
          if (!bon_rise && lives_q == LIVES_W'(1)) begin
            state_d = S_OVER;
          end else begin
`ifdef LIVES_GRACE_EN
            state_d = S_GRACE;
            timer_d = TIMER_LOAD;
`else
            state_d = S_RUN;
`endif
          end
        end else if (bon_rise) begin
          lives_d = LIVES_W'(sat_inc(32'(lives_q), MAX_LIVES));
        end
      end
`ifdef LIVES_GRACE_EN
      S_GRACE: begin
        if (bon_rise) lives_d = LIVES_W'(sat_inc(32'(lives_q), MAX_LIVES));
        if (timer_q == '0) state_d = S_RUN;
        else               timer_d = timer_q - 1'b1;
      end
`endif
      S_OVER: begin
        lives_d = '0;
        if (!startN) state_d = S_ARM;
      end
      default: begin
        state_d = S_IDLE;
        lives_d = '0;
      end
    endcase
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      lives_q     <= '0;
      life_lost_q <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      life_lost_q <= life_lost_d;
      over_q      <= (state_d == S_OVER);
    end
  end

`ifdef LIVES_GRACE_EN
  // Grace timer and the invulnerability flag that follows S_GRACE.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timer_q <= '0;
      invul_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      invul_q <= (state_d == S_GRACE);
    end
  end

  assign invulnerable = invul_q;
`else
  assign invulnerable = 1'b0;
`endif

  assign livesNum  = lives_q;
  assign lifeLost  = life_lost_q;
  assign gameOver  = over_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lives_manager.sv
// tb_lives_manager: randomized and directed stimulus for lives_manager,
// checked against a rule-level game model (phase name, integer lives,
// remaining grace clocks). Works with or without LIVES_GRACE_EN.
module tb_lives_manager;
  import lives_pkg::*;

  localparam int MAX_L   = 5;
  localparam int INIT_L  = 3;
  localparam int GRACE_N = 4;
  localparam int LW      = $clog2(MAX_L + 1);
`ifdef LIVES_GRACE_EN
  localparam bit GRACE_EN = 1'b1;
`else
  localparam bit GRACE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          resetN;
  logic          startN, collision, bonus;
  logic [LW-1:0] livesNum;
  logic          lifeLost, invulnerable, gameOver;
  lives_state_e  dbg_state;

  always #5 clk = ~clk;

  lives_manager #(
    .MAX_LIVES    (MAX_L),
    .INIT_LIVES   (INIT_L),
    .GRACE_CYCLES (GRACE_N)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startN       (startN),
    .collision    (collision),
    .bonus        (bonus),
    .livesNum     (livesNum),
    .lifeLost     (lifeLost),
    .invulnerable (invulnerable),
    .gameOver     (gameOver),
    .dbg_state    (dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {P_IDLE, P_ARM, P_RUN, P_GRACE, P_OVER} phase_e;
  phase_e m_phase;
  int     m_lives, m_grace_left;
  bit     m_prev_c, m_prev_b, m_lost;

  task automatic model_reset();
    m_phase = P_IDLE; m_lives = 0; m_grace_left = 0;
    m_prev_c = 0; m_prev_b = 0; m_lost = 0;
  endtask

  task automatic model_step(input bit s, input bit c, input bit b);
    bit hit, pick;
    hit  = c && !m_prev_c;
    pick = b && !m_prev_b;
    m_prev_c = c; m_prev_b = b;
    m_lost = 0;
    case (m_phase)
      P_IDLE: if (!s) m_phase = P_ARM;
      P_ARM:  if (s) begin m_phase = P_RUN; m_lives = INIT_L; end
      P_RUN: begin
        if (hit) begin
          m_lost = 1;
          if (!pick) m_lives = m_lives - 1;
          if (m_lives == 0) m_phase = P_OVER;
          else if (GRACE_EN) begin m_phase = P_GRACE; m_grace_left = GRACE_N; end
        end else if (pick) begin
          m_lives = (m_lives + 1 > MAX_L) ? MAX_L : m_lives + 1;
        end
      end
      P_GRACE: begin
        if (pick) m_lives = (m_lives + 1 > MAX_L) ? MAX_L : m_lives + 1;
        m_grace_left = m_grace_left - 1;
        if (m_grace_left == 0) m_phase = P_RUN;
      end
      P_OVER: if (!s) m_phase = P_ARM;
      default: m_phase = P_IDLE;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  logic [LW+2:0] exp_q[$];
  int lost_cnt, inv_cnt;

  // One clock: drive inputs, advance model at the edge, compare at negedge.
  task automatic step(input bit s, input bit c, input bit b);
    logic [LW+2:0] e;
    startN = s; collision = c; bonus = b;
    @(posedge clk);
    model_step(s, c, b);
    exp_q.push_back({LW'(m_lives), m_lost, (m_phase == P_GRACE), (m_phase == P_OVER)});
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("livesNum",     32'(livesNum),     32'(e[LW+2:3]));
    check_eq("lifeLost",     32'(lifeLost),     32'(e[2]));
    check_eq("invulnerable", 32'(invulnerable), 32'(e[1]));
    check_eq("gameOver",     32'(gameOver),     32'(e[0]));
    lost_cnt += int'(lifeLost);
    inv_cnt  += int'(invulnerable);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_lives"}, 32'(livesNum),     32'd0);
    check_eq({tag, "_lost"},  32'(lifeLost),     32'd0);
    check_eq({tag, "_inv"},   32'(invulnerable), 32'd0);
    check_eq({tag, "_over"},  32'(gameOver),     32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state),    32'(S_IDLE));
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic start_game();
    step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetN = 1'b0; startN = 1'b1; collision = 1'b0; bonus = 1'b0;
    lost_cnt = 0; inv_cnt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    resetN = 1'b1;

    // Start: two clocks low, then release.
    start_game();
    check_eq("start_lives", 32'(livesNum), 32'(INIT_L));
    check_eq("start_over",  32'(gameOver), 32'd0);

    // Collision held for 10 clocks counts once.
    lost_cnt = 0; inv_cnt = 0;
    repeat (10) step(1, 1, 0);
    repeat (6)  step(1, 0, 0);
    check_eq("hold_lost_cnt", 32'(lost_cnt), 32'd1);
    check_eq("hold_inv_cnt",  32'(inv_cnt),  GRACE_EN ? 32'(GRACE_N) : 32'd0);
    check_eq("hold_lives",    32'(livesNum), 32'(INIT_L - 1));

    // Three spaced collisions end the game; bonuses then do nothing.
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0);
      repeat (7) step(1, 0, 0);
    end
    check_eq("over_flag",  32'(gameOver), 32'd1);
    repeat (3) begin step(1, 0, 1); step(1, 0, 0); end
    check_eq("over_lives", 32'(livesNum), 32'd0);

    // Restart from S_OVER and saturate with four bonuses.
    step(0, 0, 0); step(1, 0, 0);
    check_eq("restart_lives", 32'(livesNum), 32'(INIT_L));
    repeat (4) begin step(1, 0, 1); step(1, 0, 0); end
    check_eq("sat_lives", 32'(livesNum), 32'(MAX_L));

    // Simultaneous collision and bonus at INIT_L lives.
    do_reset();
    start_game();
    step(1, 1, 1);
    check_eq("both_lost",  32'(lifeLost),     32'd1);
    check_eq("both_lives", 32'(livesNum),     32'(INIT_L));
    check_eq("both_inv",   32'(invulnerable), 32'(GRACE_EN));
    repeat (6) step(1, 0, 0);

    // Asynchronous reset mid-grace at two lives.
    step(1, 1, 0);
    step(1, 0, 0);
    #2 resetN = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    resetN = 1'b1;

    // Back-to-back collisions one clock apart.
    start_game();
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    check_eq("b2b_lives", 32'(livesNum), GRACE_EN ? 32'(INIT_L - 1) : 32'(INIT_L - 2));
    repeat (6) step(1, 0, 0);

    // Randomized play.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
